// File: rtl/alu_if.sv
// alu_if: operand / opcode / result bundle for the alu datapath block.
//   A_i    4  operand A, unsigned           (master -> slave)
//   B_i    4  operand B, unsigned           (master -> slave)
//   opSel  3  operation select              (master -> slave)
//   r_alu  8  registered result             (slave -> master)
// The master is the operand supplier; the slave is the alu itself.
interface alu_if;
  logic [3:0] A_i;
  logic [3:0] B_i;
  logic [2:0] opSel;
  logic [7:0] r_alu;

  modport master (
    output A_i,
    output B_i,
    output opSel,
    input  r_alu
  );

  modport slave (
    input  A_i,
    input  B_i,
    input  opSel,
    output r_alu
  );
endinterface

// File: rtl/alu.sv
// alu: 4-bit operand arithmetic/logic unit with a registered 8-bit result.
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset; clears r_alu immediately
//   bus    alu_if.slave: A_i, B_i, opSel in; r_alu out
// Operands are zero-extended to 8 bits and every result wraps modulo 256.
// One cycle of latency, a new operation is accepted every cycle.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [2:0] shamt;
  logic [7:0] r_alu_d;
  logic [7:0] r_alu_q;

  assign a_ext = {4'b0000, bus.A_i};
  assign b_ext = {4'b0000, bus.B_i};
  // Only the low three bits of B_i select a shift distance; bit 3 is ignored.
  assign shamt = bus.B_i[2:0];

  always_comb begin
    r_alu_d = 8'h00;
    unique case (op_e'(bus.opSel))
      OP_ADD: r_alu_d = a_ext + b_ext;
      // 8-bit subtraction wraps naturally into two's complement.
      OP_SUB: r_alu_d = a_ext - b_ext;
      // 4x4 product never exceeds 8 bits, so no truncation occurs.
      OP_MUL: r_alu_d = a_ext * b_ext;
      OP_AND: r_alu_d = a_ext & b_ext;
      OP_OR:  r_alu_d = a_ext | b_ext;
      OP_XOR: r_alu_d = a_ext ^ b_ext;
      OP_SHL: r_alu_d = a_ext << shamt;
      OP_SHR: r_alu_d = a_ext >> shamt;
      default: r_alu_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_q <= 8'h00;
    end else begin
      r_alu_q <= r_alu_d;
    end
  end

  assign bus.r_alu = r_alu_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic model.
module tb_alu;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_if u_if ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, result reduced modulo 256.
  function automatic logic [7:0] model(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a * (1 << (b % 8));
      7: r = a / (1 << (b % 8));
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    return 8'(r);
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (u_if.r_alu === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, u_if.r_alu, exp);
    end
  endtask

  // Drive one operation just after an edge, check it one edge later.
  task automatic apply(input string tag, input int a, input int b, input int op);
    u_if.A_i   = 4'(a);
    u_if.B_i   = 4'(b);
    u_if.opSel = 3'(op);
    @(posedge clk);
    #1;
    check(tag, model(a, b, op));
  endtask

  task automatic apply_exp(input string tag, input int a, input int b, input int op,
                           input logic [7:0] exp);
    u_if.A_i   = 4'(a);
    u_if.B_i   = 4'(b);
    u_if.opSel = 3'(op);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    u_if.A_i    = 4'h7;
    u_if.B_i    = 4'h2;
    u_if.opSel  = 3'd0;

    // Reset held for two cycles.
    #1;
    check("reset_t0", 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", 8'h00);

    // Release mid-cycle: output must stay zero until the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_release", 8'h00);
    @(posedge clk);
    #1;
    check("first_after_release", model(7, 2, 0));

    // Directed boundary cases with hand-computed expectations.
    apply_exp("add_max",   15, 15, 0, 8'h1E);
    apply_exp("mul_max",   15, 15, 2, 8'hE1);
    apply_exp("xor_same",  15, 15, 5, 8'h00);
    apply_exp("sub_neg",    3,  5, 1, 8'hFE);
    apply_exp("sub_zero",   0,  0, 1, 8'h00);
    apply_exp("sub_equal",  9,  9, 1, 8'h00);
    apply_exp("shl_9_3",    9,  3, 6, 8'h48);
    apply_exp("shr_9_3",    9,  3, 7, 8'h01);
    apply_exp("shl_b3_ign", 9, 11, 6, 8'h48);
    apply_exp("shr_b3_ign", 9, 11, 7, 8'h01);
    apply_exp("shl_by0",   13,  0, 6, 8'h0D);
    apply_exp("shr_by0",   13,  8, 7, 8'h0D);
    apply_exp("shl_by7",   15,  7, 6, 8'h80);
    apply_exp("shl_by7_e", 14,  7, 6, 8'h00);
    apply_exp("and_mix",   12, 10, 3, 8'h08);
    apply_exp("or_mix",    12, 10, 4, 8'h0E);

    // Exhaustive sweep of every operand/opcode combination.
    for (int op = 0; op < 8; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          apply("sweep", a, b, op);
        end
      end
    end

    // Randomized stream.
    for (int i = 0; i < 300; i++) begin
      apply("random", int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(7)));
    end

    // Reset asserted mid-stream clears the output before the next edge.
    apply("pre_reset", 15, 15, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_clear", 8'h00);
    u_if.A_i   = 4'h6;
    u_if.B_i   = 4'h5;
    u_if.opSel = 3'd2;
    @(posedge clk);
    #1;
    check("reset_mid_hold", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_release_zero", 8'h00);
    @(posedge clk);
    #1;
    check("resume", 8'h1E);
    apply("resume_next", 10, 4, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
